// File: rtl/mx8_scan_seq.sv
// Byte-to-serial sequencer for the 8:1 select mux: holds one byte on the mux
// data inputs and steps the select lines once per accepted bit.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no byte in flight; ser_bit = IDLE_BIT, din_ready high
// ST_SHIFT | byte held in r_hold; r_cnt = number of bits already accepted
module mx8_scan_seq #(
  parameter bit   MSB_FIRST = 1'b0,
  parameter logic IDLE_BIT  = 1'b1
) (
  input  logic       sys_clk,
  input  logic       resetl,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [7:0] hold_q,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       ser_bit,
  output logic       bit_valid,
  output logic       bit_last,
  input  logic       bit_ready,
  output logic       busy
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t     r_state;
  logic [2:0] r_cnt;
  logic [7:0] r_hold;

  logic       w_shift;
  logic       w_last;
  logic       w_load;
  logic [2:0] w_sel;

  assign w_shift = (r_state == ST_SHIFT);
  assign w_sel   = MSB_FIRST ? (3'd7 - r_cnt) : r_cnt;
  assign w_last  = w_shift && (r_cnt == 3'd7);

  // Ready never looks at din_valid, so there is no valid->ready loop.
  assign din_ready = resetl && (!w_shift || (w_last && bit_ready));
  assign w_load    = din_valid && din_ready;

  always_ff @(posedge sys_clk) begin
    if (!resetl) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
      r_hold  <= 8'h00;
    end else if (w_load) begin
      // Covers both a fresh start from idle and the back-to-back reload on bit 8.
      r_state <= ST_SHIFT;
      r_cnt   <= 3'd0;
      r_hold  <= din;
    end else if (w_shift && bit_ready) begin
      if (r_cnt == 3'd7) begin
        r_state <= ST_IDLE;
        r_cnt   <= 3'd0;
      end else begin
        r_cnt <= r_cnt + 3'd1;
      end
    end
  end

  assign hold_q    = r_hold;
  assign {s2, s1, s0} = w_sel;
  assign busy      = w_shift;
  assign bit_valid = w_shift;
  assign bit_last  = w_last;
  assign ser_bit   = w_shift ? r_hold[w_sel] : IDLE_BIT;

endmodule

// File: tb/tb_mx8_scan_seq.sv
// Bench for mx8_scan_seq: LSB-first and MSB-first instances share stimulus;
// a per-bit scoreboard checks every cycle, table vectors check whole bytes.
module tb_mx8_scan_seq;

  logic       sys_clk = 1'b0;
  logic       resetl;
  logic [7:0] din;
  logic       din_valid;
  logic       bit_ready;

  logic       rdy0, s00, s10, s20, ser0, val0, last0, busy0;
  logic       rdy1, s01, s11, s21, ser1, val1, last1, busy1;
  logic [7:0] hold0, hold1;

  always #5 sys_clk = ~sys_clk;

  mx8_scan_seq #(.MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
    .sys_clk(sys_clk), .resetl(resetl), .din(din), .din_valid(din_valid),
    .din_ready(rdy0), .hold_q(hold0), .s0(s00), .s1(s10), .s2(s20),
    .ser_bit(ser0), .bit_valid(val0), .bit_last(last0),
    .bit_ready(bit_ready), .busy(busy0)
  );

  mx8_scan_seq #(.MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_msb (
    .sys_clk(sys_clk), .resetl(resetl), .din(din), .din_valid(din_valid),
    .din_ready(rdy1), .hold_q(hold1), .s0(s01), .s1(s11), .s2(s21),
    .ser_bit(ser1), .bit_valid(val1), .bit_last(last1),
    .bit_ready(bit_ready), .busy(busy1)
  );

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: one entry per expected serial bit {bit, sel, last}.
  typedef struct {
    logic       b;
    logic [2:0] s;
    logic       l;
  } ent_t;

  ent_t       q0[$];
  ent_t       q1[$];
  logic [7:0] exp_hold = 8'h00;
  logic       sb_en = 1'b0;

  always @(negedge sys_clk) begin
    if (sb_en) begin
      logic exp_rdy;
      exp_rdy = resetl && (q0.size() == 0 || (q0.size() == 1 && bit_ready));
      chk("din_ready_lsb", 16'(rdy0), 16'(exp_rdy));
      chk("din_ready_msb", 16'(rdy1), 16'(exp_rdy));
      chk("hold_q_lsb", 16'(hold0), 16'(exp_hold));
      chk("hold_q_msb", 16'(hold1), 16'(exp_hold));
      if (q0.size() == 0) begin
        chk("idle_lsb", 16'({busy0, val0, last0, ser0, s20, s10, s00}), 16'(7'b000_1_000));
        chk("idle_msb", 16'({busy1, val1, last1, ser1, s21, s11, s01}), 16'(7'b000_1_111));
      end else begin
        chk("bit_lsb", 16'({busy0, val0, last0, ser0, s20, s10, s00}),
            16'({2'b11, q0[0].l, q0[0].b, q0[0].s}));
        chk("bit_msb", 16'({busy1, val1, last1, ser1, s21, s11, s01}),
            16'({2'b11, q1[0].l, q1[0].b, q1[0].s}));
      end
      // Apply what the coming rising edge will do.
      if (!resetl) begin
        q0.delete();
        q1.delete();
        exp_hold = 8'h00;
      end else begin
        if (q0.size() != 0 && bit_ready) begin
          void'(q0.pop_front());
          void'(q1.pop_front());
        end
        if (din_valid && exp_rdy) begin
          exp_hold = din;
          for (int k = 0; k < 8; k++) begin
            q0.push_back('{b: din[k], s: 3'(k), l: (k == 7)});
            q1.push_back('{b: din[7-k], s: 3'(7 - k), l: (k == 7)});
          end
        end
      end
    end
  end

  // Collector of consumed bits, first bit ends up most significant.
  logic [15:0] col0, col1;
  int          ncol;
  always @(negedge sys_clk) begin
    if (sb_en && val0 && bit_ready) begin
      col0 = {col0[14:0], ser0};
      col1 = {col1[14:0], ser1};
      ncol++;
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clr_col();
    col0 = '0;
    col1 = '0;
    ncol = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    din       = b;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    din       = ~b;
    repeat (8) tick();
  endtask

  typedef struct {
    logic [7:0] d;
    logic [7:0] seq_lsb;
    logic [7:0] seq_msb;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{d: 8'hA5, seq_lsb: 8'b1010_0101, seq_msb: 8'b1010_0101};
    vecs[1] = '{d: 8'h01, seq_lsb: 8'b1000_0000, seq_msb: 8'b0000_0001};
    vecs[2] = '{d: 8'h80, seq_lsb: 8'b0000_0001, seq_msb: 8'b1000_0000};
    vecs[3] = '{d: 8'hC6, seq_lsb: 8'b0110_0011, seq_msb: 8'b1100_0110};

    resetl    = 1'b0;
    din       = 8'h00;
    din_valid = 1'b0;
    bit_ready = 1'b1;
    clr_col();

    // Reset/idle: two checked cycles in reset, then release.
    tick();
    sb_en = 1'b1;
    tick();
    tick();
    resetl = 1'b1;
    @(negedge sys_clk);
    chk("ready_after_reset", 16'({rdy0, rdy1}), 16'(2'b11));
    tick();

    // Single bytes, bit_ready held high.
    for (int i = 0; i < 4; i++) begin
      clr_col();
      send_byte(vecs[i].d);
      chk("vec_lsb", {8'h00, col0[7:0]}, {8'h00, vecs[i].seq_lsb});
      chk("vec_msb", {8'h00, col1[7:0]}, {8'h00, vecs[i].seq_msb});
      chk("vec_count", 16'(ncol), 16'd8);
    end

    // Back-to-back F0 then 0F with din_valid held.
    begin
      logic [15:0] rdy_seen;
      clr_col();
      rdy_seen  = '0;
      din       = 8'hF0;
      din_valid = 1'b1;
      tick();
      din = 8'h0F;
      for (int k = 0; k < 16; k++) begin
        @(negedge sys_clk);
        rdy_seen[15-k] = rdy0;
        tick();
        if (k == 7) din_valid = 1'b0;
      end
      chk("b2b_lsb", col0, 16'b0000_1111_1111_0000);
      chk("b2b_msb", col1, 16'b1111_0000_0000_1111);
      chk("b2b_count", 16'(ncol), 16'd16);
      chk("b2b_ready", rdy_seen, 16'b0000_0001_0000_0001);
    end

    // Stall at cnt=2 and at cnt=7.
    clr_col();
    din       = 8'h3C;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    tick();
    tick();
    bit_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge sys_clk);
      chk("stall2_state", 16'({s20, s10, s00, last0, ser0, s21, s11, s01}), 16'(8'b010_0_1_101));
      tick();
    end
    bit_ready = 1'b1;
    repeat (5) tick();
    bit_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge sys_clk);
      chk("stall7_state", 16'({s20, s10, s00, last0, ser0, rdy0, last1, ser1}), 16'(8'b111_1_0_0_1_0));
      tick();
    end
    bit_ready = 1'b1;
    tick();
    chk("stall_lsb", {8'h00, col0[7:0]}, 16'h003C);
    chk("stall_msb", {8'h00, col1[7:0]}, 16'h003C);
    chk("stall_count", 16'(ncol), 16'd8);

    // Reset in the middle of a byte.
    din       = 8'hFF;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (4) tick();
    resetl = 1'b0;
    tick();
    resetl = 1'b1;
    @(negedge sys_clk);
    chk("midrst_state", 16'({busy0, s20, s10, s00, busy1, s21, s11, s01}), 16'(8'b0_000_0_111));
    chk("midrst_hold", {hold0, hold1}, 16'h0000);
    tick();
    clr_col();
    send_byte(8'h81);
    chk("after_rst_lsb", {8'h00, col0[7:0]}, 16'h0081);
    chk("after_rst_msb", {8'h00, col1[7:0]}, 16'h0081);
    chk("after_rst_count", 16'(ncol), 16'd8);
    tick();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/mx8_scan_seq.md
Name: mx8_scan_seq

Overview:
- Upstream sequencer for the 8:1 select mux cell.
- Accepts one parallel byte per handshake and holds it on `hold_q[7:0]`, which drives the mux data inputs a0..a7.
- Steps the 3-bit select {s2,s1,s0} through all eight positions, one bit per accepted beat, so the mux output becomes a serial bit stream.
- Also produces the selected bit internally (`ser_bit`) for downstream logic and verification, together with valid/last flags.

Parameters:
- MSB_FIRST, 0, 0: select order 0→7 (a0 first); 1: order 7→0 (a7 first)
- IDLE_BIT, 1'b1, value driven on `ser_bit` while no byte is in flight

Ports:
- sys_clk, input, 1, system clock; all state updates on rising edge
- resetl, input, 1, synchronous active-low reset, sampled on rising edge of sys_clk
- din, input, 8, parallel byte to serialize
- din_valid, input, 1, din is valid
- din_ready, output, 1, block can accept din this cycle
- hold_q, output, 8, registered byte; bit n drives mux input a<n>
- s0, output, 1, select bit 0 to mux
- s1, output, 1, select bit 1 to mux
- s2, output, 1, select bit 2 to mux
- ser_bit, output, 1, hold_q[{s2,s1,s0}] while busy, else IDLE_BIT
- bit_valid, output, 1, ser_bit is a valid serial bit this cycle
- bit_last, output, 1, current bit is the eighth of the byte
- bit_ready, input, 1, downstream consumes ser_bit this cycle
- busy, output, 1, a byte is in flight

Behaviour:
- **State machine.**
  - States IDLE and SHIFT; 3-bit counter cnt (0..7) counts accepted bits.
  - {s2,s1,s0} = MSB_FIRST ? 7-cnt : cnt, always, including in IDLE.
  - busy = bit_valid = (state==SHIFT).
  - bit_last = busy && cnt==7.
  - ser_bit = busy ? hold_q[{s2,s1,s0}] : IDLE_BIT.
- **Accept.**
  - din_ready = resetl && (state==IDLE || (bit_last && bit_ready)). This is combinational, with no combinational path from din_valid.
  - load = din_valid && din_ready.
  - On load: hold_q ← din, cnt ← 0, state ← SHIFT.
  - First bit is valid in the cycle after load (latency 1).
- **Bit step.**
  - In SHIFT with bit_ready=1 and cnt<7: cnt ← cnt+1.
  - With bit_ready=0: cnt, hold_q and the selects stay unchanged. ser_bit is stable while stalled.
- **Byte end.**
  - In SHIFT, cnt==7, bit_ready=1:
    - if load in the same cycle, reload as above and stay in SHIFT (back-to-back; no bubble between the eighth bit and the next byte's first bit);
    - otherwise state ← IDLE and cnt ← 0.
- **Wrap.** cnt never increments past 7; the 7→0 transition happens only via byte end.
- **din changes.** din changes while not loaded are ignored; hold_q changes only on load.
- **Reset** (resetl=0 at a rising edge, from any state, including mid-byte):
  - state ← IDLE, cnt ← 0, hold_q ← 8'h00;
  - outputs then read busy=0, bit_valid=0, bit_last=0, ser_bit=IDLE_BIT, {s2,s1,s0}=MSB_FIRST?3'b111:3'b000;
  - din_ready=0 while resetl=0;
  - a partially sent byte is discarded; no bits are emitted for it after reset.
- **Throughput.** Eight bits per byte at one bit per cycle when bit_ready is held 1. Sustained rate is 1 byte per 8 cycles with back-to-back loading.

Test Plan:
1. Reset/idle: MSB_FIRST=0; hold resetl=0 for 2 cycles, then release.
   - During reset: din_ready=0, busy=0, ser_bit=1, sel=000, hold_q=00.
   - After release: din_ready=1.
2. Single byte, LSB first: din=8'hA5, din_valid pulse 1 cycle, bit_ready=1.
   - From the next cycle, ser_bit = 1,0,1,0,0,1,0,1 over 8 cycles.
   - sel = 0..7; bit_last=1 only on the eighth bit.
   - Then IDLE: ser_bit=1, din_ready=1.
3. MSB first: MSB_FIRST=1, din=8'hA5.
   - ser_bit = 1,0,1,0,0,1,0,1 with sel = 7..0.
   - Repeat with din=8'h01: bits 0,0,0,0,0,0,0,1.
4. Back-to-back: din=8'hF0 then 8'h0F; din_valid held 1, bit_ready=1.
   - 16 contiguous valid bits: 0000_1111, then 1111_0000 (LSB first).
   - din_ready=1 only in the load cycle and on the eighth bit of each byte; no idle cycle in between.
5. Stall: din=8'h3C; drop bit_ready for 3 cycles at cnt=2 and again at cnt=7.
   - sel, ser_bit and bit_last hold during each stall.
   - Full sequence 0,0,1,1,1,1,0,0 is still delivered.
   - din_ready stays 0 during the cnt=7 stall.
6. Reset mid-byte: load 8'hFF, assert resetl=0 at cnt=4 for 1 cycle.
   - Next cycle: busy=0, cnt/sel=000, hold_q=00.
   - A new byte 8'h81 loaded afterwards serializes 1,0,0,0,0,0,0,1.
